nxn_switch_allocator: RTL and testbench



---
 rtl/nxn_switch_allocator.sv | 132 +++++++++++++
 tb/tb_nxn_switch_allocator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nxn_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking.
// Each output grants one unlocked requester per cycle and stays with it until that packet's tail flit.
//
// state  | meaning
// IDLE   | output free; round-robin among unlocked inputs requesting it
// LOCKED | output held by owner until its tail flit transfers
module nxn_switch_allocator #(
  parameter int IN_N  = 5,
  parameter int OUT_M = 5,
  localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1,
  localparam int DST_W = (OUT_M > 1) ? $clog2(OUT_M) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IN_N-1:0]        valid_i,
  input  logic [IN_N*DST_W-1:0]  dst_i,
  input  logic [IN_N-1:0]        last_i,
  input  logic [OUT_M-1:0]       out_ready_i,
  output logic [IN_N-1:0]        grant_o,
  output logic [OUT_M-1:0]       out_valid_o,
  output logic [OUT_M*SEL_W-1:0] sel_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q [OUT_M];
  state_e           state_d [OUT_M];
  logic [SEL_W-1:0] owner_q [OUT_M];
  logic [SEL_W-1:0] owner_d [OUT_M];
  logic [SEL_W-1:0] rr_ptr_q [OUT_M];
  logic [SEL_W-1:0] rr_ptr_d [OUT_M];
  logic [IN_N-1:0]  in_locked_q;
  logic [IN_N-1:0]  in_locked_d;

  logic [IN_N-1:0]  cand [OUT_M];
  logic             found;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] own;
  int               idx;

  // An input already carrying a packet never competes for another output.
  always_comb begin
    for (int m = 0; m < OUT_M; m++) begin
      for (int i = 0; i < IN_N; i++) begin
        cand[m][i] = valid_i[i] && !in_locked_q[i] &&
                     (dst_i[i*DST_W +: DST_W] == DST_W'(m));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    in_locked_d = in_locked_q;
    grant_o     = '0;
    out_valid_o = '0;
    sel_o       = '0;
    found       = 1'b0;
    win         = '0;
    own         = '0;
    idx         = 0;

    for (int m = 0; m < OUT_M; m++) begin
      sel_o[m*SEL_W +: SEL_W] = owner_q[m];
      found = 1'b0;
      win   = '0;
      own   = owner_q[m];

      if (state_q[m] == IDLE) begin
        if (out_ready_i[m]) begin
          for (int k = 0; k < IN_N; k++) begin
            idx = (int'(rr_ptr_q[m]) + k) % IN_N;
            if (!found && cand[m][idx]) begin
              found = 1'b1;
              win   = SEL_W'(idx);
            end
          end
          if (found) begin
            grant_o[win]            = 1'b1;
            out_valid_o[m]          = 1'b1;
            sel_o[m*SEL_W +: SEL_W] = win;
            owner_d[m]              = win;
            rr_ptr_d[m]             = SEL_W'((int'(win) + 1) % IN_N);
            if (!last_i[win]) begin
              state_d[m]       = LOCKED;
              in_locked_d[win] = 1'b1;
            end
          end
        end
      end else begin
        if (valid_i[own] && out_ready_i[m]) begin
          grant_o[own]   = 1'b1;
          out_valid_o[m] = 1'b1;
          if (last_i[own]) begin
            state_d[m]       = IDLE;
            in_locked_d[own] = 1'b0;
          end
        end
      end
    end

    // Outputs stay quiet for the whole reset, not only after the flops clear.
    if (rst_i) begin
      grant_o     = '0;
      out_valid_o = '0;
      sel_o       = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int m = 0; m < OUT_M; m++) begin
        state_q[m]  <= IDLE;
        owner_q[m]  <= '0;
        rr_ptr_q[m] <= '0;
      end
      in_locked_q <= '0;
    end else begin
      for (int m = 0; m < OUT_M; m++) begin
        state_q[m]  <= state_d[m];
        owner_q[m]  <= owner_d[m];
        rr_ptr_q[m] <= rr_ptr_d[m];
      end
      in_locked_q <= in_locked_d;
    end
  end

endmodule

// File: tb/tb_nxn_switch_allocator.sv
// Directed bench for nxn_switch_allocator: single flits, round robin, wormhole lock,
// backpressure, out-of-range destinations, parallel traffic and reset mid-packet.
module tb_nxn_switch_allocator;

  localparam int IN_N  = 5;
  localparam int OUT_M = 5;
  localparam int SEL_W = 3;
  localparam int DST_W = 3;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic [IN_N-1:0]        valid_i;
  logic [IN_N*DST_W-1:0]  dst_i;
  logic [IN_N-1:0]        last_i;
  logic [OUT_M-1:0]       out_ready_i;
  logic [IN_N-1:0]        grant_o;
  logic [OUT_M-1:0]       out_valid_o;
  logic [OUT_M*SEL_W-1:0] sel_o;

  int total = 0;
  int bad   = 0;
  int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

  nxn_switch_allocator #(.IN_N(IN_N), .OUT_M(OUT_M)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .dst_i       (dst_i),
    .last_i      (last_i),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .out_valid_o (out_valid_o),
    .sel_o       (sel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic [4:0] l, input logic [4:0] r);
    valid_i     = v;
    last_i      = l;
    out_ready_i = r;
    #1;
  endtask

  task automatic set_dst(input int i, input int d);
    dst_i[i*DST_W +: DST_W] = 3'(d);
  endtask

  function automatic logic [2:0] sel(input int m);
    return sel_o[m*SEL_W +: SEL_W];
  endfunction

  initial begin
    valid_i     = '0;
    last_i      = '0;
    out_ready_i = '0;
    dst_i       = '0;
    #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_ovalid", 32'(out_valid_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    tick();
    tick();
    rst_i = 1'b0;

    // single-flit packet, then pointer of output 1 must sit at 3
    set_dst(2, 1);
    drive(5'b00100, 5'b00100, 5'b11111);
    chk("single_grant", 32'(grant_o), 32'h04);
    chk("single_ovalid", 32'(out_valid_o), 32'h02);
    chk("single_sel1", 32'(sel(1)), 32'd2);
    tick();
    set_dst(1, 1);
    set_dst(3, 1);
    drive(5'b01110, 5'b01110, 5'b11111);
    chk("rrptr1_grant", 32'(grant_o), 32'h08);
    chk("rrptr1_sel1", 32'(sel(1)), 32'd3);
    tick();

    // round robin on output 4
    set_dst(0, 4);
    set_dst(1, 4);
    set_dst(3, 4);
    for (int k = 0; k < 6; k++) begin
      drive(5'b01011, 5'b01011, 5'b11111);
      chk("rr_grant", 32'(grant_o), 32'(1 << rr_seq[k]));
      chk("rr_ovalid", 32'(out_valid_o), 32'h10);
      chk("rr_sel4", 32'(sel(4)), 32'(rr_seq[k]));
      tick();
    end

    // wormhole: 4-flit packet from input 1 holds output 0 against input 2
    set_dst(1, 0);
    set_dst(2, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) set_dst(1, 3);
      drive(5'b00110, (c == 3) ? 5'b00110 : 5'b00100, 5'b11111);
      chk("worm_grant", 32'(grant_o), 32'h02);
      chk("worm_ovalid", 32'(out_valid_o), 32'h01);
      chk("worm_sel0", 32'(sel(0)), 32'd1);
      tick();
    end
    drive(5'b00100, 5'b00100, 5'b11111);
    chk("worm_next_grant", 32'(grant_o), 32'h04);
    chk("worm_next_ovalid", 32'(out_valid_o), 32'h01);
    chk("worm_next_sel0", 32'(sel(0)), 32'd2);
    tick();

    // backpressure and bubble on output 3 locked to input 0
    set_dst(0, 3);
    set_dst(4, 3);
    drive(5'b00001, 5'b00000, 5'b11111);
    chk("bp_head_grant", 32'(grant_o), 32'h01);
    chk("bp_head_ovalid", 32'(out_valid_o), 32'h08);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(5'b10001, 5'b10000, 5'b10111);
      chk("bp_stall_grant", 32'(grant_o), 32'h0);
      chk("bp_stall_ovalid", 32'(out_valid_o), 32'h0);
      chk("bp_stall_sel3", 32'(sel(3)), 32'd0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(5'b10000, 5'b10000, 5'b11111);
      chk("bp_bubble_grant", 32'(grant_o), 32'h0);
      chk("bp_bubble_ovalid", 32'(out_valid_o), 32'h0);
      tick();
    end
    drive(5'b10001, 5'b10001, 5'b11111);
    chk("bp_tail_grant", 32'(grant_o), 32'h01);
    chk("bp_tail_ovalid", 32'(out_valid_o), 32'h08);
    tick();
    drive(5'b10000, 5'b10000, 5'b11111);
    chk("bp_after_grant", 32'(grant_o), 32'h10);
    chk("bp_after_sel3", 32'(sel(3)), 32'd4);
    tick();

    // out-of-range destinations never win
    set_dst(0, 7);
    set_dst(1, 5);
    drive(5'b00011, 5'b00011, 5'b11111);
    chk("oor_grant", 32'(grant_o), 32'h0);
    chk("oor_ovalid", 32'(out_valid_o), 32'h0);
    tick();

    // parallel: input i -> output 4-i
    for (int i = 0; i < IN_N; i++) set_dst(i, 4 - i);
    drive(5'b11111, 5'b11111, 5'b11111);
    chk("par_grant", 32'(grant_o), 32'h1f);
    chk("par_ovalid", 32'(out_valid_o), 32'h1f);
    for (int m = 0; m < OUT_M; m++) chk("par_sel", 32'(sel(m)), 32'(4 - m));
    tick();

    // reset while output 2 is locked to input 4
    set_dst(4, 2);
    drive(5'b10000, 5'b00000, 5'b11111);
    chk("rmp_head_grant", 32'(grant_o), 32'h10);
    chk("rmp_head_sel2", 32'(sel(2)), 32'd4);
    tick();
    drive(5'b10000, 5'b00000, 5'b11111);
    chk("rmp_body_grant", 32'(grant_o), 32'h10);
    rst_i = 1'b1;
    #1;
    chk("rmp_async_grant", 32'(grant_o), 32'h0);
    chk("rmp_async_ovalid", 32'(out_valid_o), 32'h0);
    chk("rmp_async_sel", 32'(sel_o), 32'h0);
    tick();
    rst_i = 1'b0;
    set_dst(1, 2);
    drive(5'b10010, 5'b00010, 5'b11111);
    chk("rmp_rearb_grant", 32'(grant_o), 32'h02);
    chk("rmp_rearb_sel2", 32'(sel(2)), 32'd1);
    tick();
    drive(5'b10000, 5'b00000, 5'b11111);
    chk("rmp_stale_grant", 32'(grant_o), 32'h10);
    chk("rmp_stale_sel2", 32'(sel(2)), 32'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
